// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button conditioner.
// Edge-mode encodings, counter-width helper and edge-mode sanitiser.
package btn_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Width of a counter that must hold values 0..x-1; never narrower than 1 bit.
    function automatic int cnt_w(input int x);
        return (x > 2) ? $clog2(x) : 1;
    endfunction

    // Unknown edge modes fall back to press (rise) detection.
    function automatic int edge_sel(input int mode);
        return ((mode == EDGE_FALL) || (mode == EDGE_BOTH)) ? mode : EDGE_RISE;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-FF synchroniser, counter debounce, edge-selected
// one-cycle pulse. Optional auto-repeat while held when BTN_AUTOREPEAT_EN
// is defined.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DB_CYCLES   = 16,
    parameter int EDGE_MODE   = 0,
    parameter int HOLD_CYCLES = 1000,
    parameter int REP_CYCLES  = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse,
    output logic o_pulse_next
);

    localparam int              DB_W    = cnt_w(DB_CYCLES);
    localparam int              MODE    = edge_sel(EDGE_MODE);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_level;
    logic            r_level;
    logic            r_pulse;
    logic            w_rise;
    logic            w_fall;
    logic            w_edge_pulse;
    logic            w_pulse_next;

    // Two-flop synchroniser for the asynchronous button line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // Debounce: the level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (r_s2 == r_db_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_level <= r_s2;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_rise = r_db_level & ~r_level;
    assign w_fall = ~r_db_level & r_level;

    // Pick which debounced transitions produce an event.
    always_comb begin
        w_edge_pulse = 1'b0;
        case (MODE)
            EDGE_FALL: w_edge_pulse = w_fall;
            EDGE_BOTH: w_edge_pulse = w_rise | w_fall;
            default:   w_edge_pulse = w_rise;
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int              HOLD_W    = cnt_w(max_int(HOLD_CYCLES, REP_CYCLES));
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_rep_phase;
    logic              w_hold_active;
    logic              w_rep_fire;

    // Held means both the visible and the internal debounced level are high,
    // so a pending release stops the repeat at once.
    assign w_hold_active = (MODE != EDGE_FALL) && r_level && r_db_level;
    assign w_rep_fire    = w_hold_active &&
                           (r_hold_cnt == (r_rep_phase ? REP_LAST : HOLD_LAST));

    // Hold timer: initial delay first, then the shorter repeat period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt  <= '0;
            r_rep_phase <= 1'b0;
        end else if (!w_hold_active) begin
            r_hold_cnt  <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep_fire) begin
            r_hold_cnt  <= '0;
            r_rep_phase <= 1'b1;
        end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign w_pulse_next = w_edge_pulse | w_rep_fire;
`else
    logic w_unused_cfg;

    // Repeat timing has no meaning without auto-repeat; keep the parameters referenced.
    assign w_unused_cfg = (HOLD_CYCLES > 0) ^ (REP_CYCLES > 0);
    assign w_pulse_next = w_edge_pulse;
`endif

    // Output stage: level and its event pulse appear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_level <= r_db_level;
            r_pulse <= w_pulse_next;
        end
    end

    assign o_level      = r_level;
    assign o_pulse      = r_pulse;
    assign o_pulse_next = w_pulse_next;

endmodule

// File: rtl/btn_pulse_array.sv
// Multi-channel button conditioner: N_CH independent btn_chan instances plus
// a registered OR of all channel pulses. Build option: BTN_AUTOREPEAT_EN.
module btn_pulse_array
    import btn_pkg::*;
#(
    parameter int N_CH        = 5,
    parameter int DB_CYCLES   = 16,
    parameter int EDGE_MODE   = 0,
    parameter int HOLD_CYCLES = 1000,
    parameter int REP_CYCLES  = 250
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] pulse_o,
    output logic            any_o
);

    logic [N_CH-1:0] w_pulse_next;
    logic            r_any;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            btn_chan #(
                .DB_CYCLES  (DB_CYCLES),
                .EDGE_MODE  (EDGE_MODE),
                .HOLD_CYCLES(HOLD_CYCLES),
                .REP_CYCLES (REP_CYCLES)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_btn       (btn_i[gi]),
                .o_level     (level_o[gi]),
                .o_pulse     (pulse_o[gi]),
                .o_pulse_next(w_pulse_next[gi])
            );
        end
    endgenerate

    // Register the OR of next-cycle pulses so any_o lines up with pulse_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_pulse_next;
        end
    end

    assign any_o = r_any;

endmodule
